// File: rtl/as_uart.sv
// Full-duplex 8N1 UART with a byte strobe/busy interface toward the as_wb_bridge.
// Rx and tx are independent FSMs; each one's state is visible on a debug output.
module as_uart #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic       serial_tx,
  output logic [7:0] as_data_o,
  output logic       as_dstrb_o,
  input  logic       as_busy_i,
  input  logic [7:0] as_data_i,
  input  logic       as_dstrb_i,
  output logic       as_busy_o,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o,
  output logic [2:0] rx_state_o,
  output logic [1:0] tx_state_o
);

  // Handshake (both directions): a byte moves on a rising edge where
  // strobe=1 and busy=0; the sender holds strobe and data stable until then.

  localparam logic [15:0] DIV  = 16'(CLK_DIV);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_line_q, tx_line_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Each bit lasts from the edge that loads DIV-1 until the edge where the count hits 0.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (as_dstrb_i) begin
          tx_shift_d = as_data_i;
          tx_cnt_d   = DIV - 16'd1;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = DIV - 16'd1;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = DIV - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) tx_state_d = TX_IDLE;
        else                   tx_cnt_d   = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign serial_tx  = tx_line_q;
  assign as_busy_o  = (tx_state_q != TX_IDLE);
  assign tx_state_o = tx_state_q;

  // ---------------- receiver ----------------
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  hold_q, hold_d;
  logic        dstrb_q, dstrb_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        rx_sample, deliver, frame_err, transfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      hold_q     <= '0;
      dstrb_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= serial_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      hold_q     <= hold_d;
      dstrb_q    <= dstrb_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // A count loaded with N expires (rx_sample) N edges later.
  assign rx_sample = (rx_cnt_q == 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = HALF;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_sample) begin
          rx_cnt_d = DIV;
          rx_bit_d = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_cnt_d   = DIV;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          deliver    = rx_sync_q;
          frame_err  = !rx_sync_q;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // One-entry holding register: a delivery is only dropped if the old byte stays put.
  assign transfer = dstrb_q && !as_busy_i;

  always_comb begin
    hold_d  = hold_q;
    dstrb_d = dstrb_q;
    ovr_d   = 1'b0;
    ferr_d  = frame_err;
    if (transfer) dstrb_d = 1'b0;
    if (deliver) begin
      if (!dstrb_q || transfer) begin
        hold_d  = rx_shift_q;
        dstrb_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign as_data_o      = hold_q;
  assign as_dstrb_o     = dstrb_q;
  assign rx_overrun_o   = ovr_q;
  assign rx_frame_err_o = ferr_q;
  assign rx_state_o     = rx_state_q;

endmodule

// File: tb/tb_as_uart.sv
// Directed bench for as_uart at CLK_DIV=8: tx bit timing, rx delivery,
// backpressure/overrun, glitch rejection, framing error and mid-frame reset.
module tb_as_uart;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_rx;
  logic       serial_tx;
  logic [7:0] as_data_o;
  logic       as_dstrb_o;
  logic       as_busy_i;
  logic [7:0] as_data_i;
  logic       as_dstrb_i;
  logic       as_busy_o;
  logic       rx_overrun_o;
  logic       rx_frame_err_o;
  logic [2:0] rx_state_o;
  logic [1:0] tx_state_o;

  as_uart #(.CLK_DIV(DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_rx      (serial_rx),
    .serial_tx      (serial_tx),
    .as_data_o      (as_data_o),
    .as_dstrb_o     (as_dstrb_o),
    .as_busy_i      (as_busy_i),
    .as_data_i      (as_data_i),
    .as_dstrb_i     (as_dstrb_i),
    .as_busy_o      (as_busy_o),
    .rx_overrun_o   (rx_overrun_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_state_o     (rx_state_o),
    .tx_state_o     (tx_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int cyc = 0;
  int dstrb_cycles = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  int last_rise_cyc = 0;
  int frame_start = 0;
  logic prev_dstrb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (as_dstrb_o) begin
        dstrb_cycles++;
        if (!prev_dstrb) last_rise_cyc = cyc;
        if (!as_busy_i) got_q.push_back(as_data_o);
      end
      if (rx_overrun_o) ovr_cnt++;
      if (rx_frame_err_o) ferr_cnt++;
    end
    prev_dstrb = as_dstrb_o;
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the given stop bit; leaves the line at stop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    frame_start = cyc;
    for (int i = 0; i < 10; i++) begin
      serial_rx = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  // Hands one byte to the transmitter and checks every cycle of the frame.
  task automatic tx_check(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    @(posedge clk);
    #1;
    as_data_i  = b;
    as_dstrb_i = 1'b1;
    @(posedge clk);
    #1;
    as_dstrb_i = 1'b0;
    as_data_i  = 8'h00;
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk);
      chk($sformatf("tx_%0h_line_c%0d", b, k), serial_tx, bits[k / DIV]);
      chk($sformatf("tx_%0h_busy_c%0d", b, k), as_busy_o, 1'b1);
    end
    @(negedge clk);
    chk($sformatf("tx_%0h_busy_end", b), as_busy_o, 1'b0);
    chk($sformatf("tx_%0h_line_end", b), serial_tx, 1'b1);
  endtask

  task automatic wait_busy_rise(output int c, output bit ok);
    logic prev;
    prev = as_busy_o;
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!prev && as_busy_o) begin
        ok = 1'b1;
        c = cyc;
      end
      prev = as_busy_o;
    end
  endtask

  // ---------------- directed sequence ----------------
  int base_d, base_o, base_f, lat, c1, c2;
  bit ok1, ok2;

  initial begin
    reset      = 1'b0;
    serial_rx  = 1'b1;
    as_busy_i  = 1'b0;
    as_data_i  = 8'h00;
    as_dstrb_i = 1'b0;
    #12;
    chk("rst_serial_tx", serial_tx, 1'b1);
    chk("rst_busy_o", as_busy_o, 1'b0);
    chk("rst_dstrb_o", as_dstrb_o, 1'b0);
    chk("rst_data_o", as_data_o, 8'h00);
    chk("rst_overrun", rx_overrun_o, 1'b0);
    chk("rst_frame_err", rx_frame_err_o, 1'b0);
    chk("rst_rx_state", rx_state_o, 3'd0);
    chk("rst_tx_state", tx_state_o, 2'd0);
    #11;
    reset = 1'b1;
    idle(3);

    // tx of 0xA5
    tx_check(8'hA5);

    // rx of 0x3C with no backpressure
    base_d = dstrb_cycles;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    serial_rx = 1'b1;
    idle(10);
    lat = last_rise_cyc - frame_start;
    chk("rx_3c_dstrb_one_cycle", dstrb_cycles - base_d, 1);
    chk("rx_3c_latency_in_window", (lat >= 76 && lat <= 79), 1'b1);
    chk("rx_3c_no_ferr", ferr_cnt, 0);
    check_sb("rx_3c");

    // backpressure: 0x11 held, 0x22 dropped with one overrun
    as_busy_i = 1'b1;
    base_o = ovr_cnt;
    send_frame(8'h11, 1'b1);
    serial_rx = 1'b1;
    idle(4);
    send_frame(8'h22, 1'b1);
    serial_rx = 1'b1;
    idle(10);
    chk("bp_overrun_once", ovr_cnt - base_o, 1);
    chk("bp_dstrb_held", as_dstrb_o, 1'b1);
    chk("bp_data_held", as_data_o, 8'h11);
    chk("bp_nothing_transferred", got_q.size(), 0);
    as_busy_i = 1'b0;
    exp_q.push_back(8'h11);
    idle(5);
    chk("bp_dstrb_cleared", as_dstrb_o, 1'b0);
    check_sb("bp");

    // glitch: 2-cycle low pulse is ignored, then 0x0F
    base_d = dstrb_cycles;
    base_f = ferr_cnt;
    serial_rx = 1'b0;
    idle(2);
    serial_rx = 1'b1;
    idle(20);
    chk("glitch_no_dstrb", dstrb_cycles - base_d, 0);
    chk("glitch_no_ferr", ferr_cnt - base_f, 0);
    chk("glitch_rx_idle", rx_state_o, 3'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    serial_rx = 1'b1;
    idle(10);
    check_sb("glitch_0f");

    // framing error on 0x55, line held low, then 0xF0
    base_d = dstrb_cycles;
    base_f = ferr_cnt;
    send_frame(8'h55, 1'b0);
    idle(20);
    serial_rx = 1'b1;
    idle(10);
    chk("frame_err_once", ferr_cnt - base_f, 1);
    chk("frame_no_dstrb", dstrb_cycles - base_d, 0);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1);
    serial_rx = 1'b1;
    idle(10);
    check_sb("frame_f0");

    // full duplex: transmit 0x5A while receiving 0xC3
    exp_q.push_back(8'hC3);
    fork
      tx_check(8'h5A);
      begin
        send_frame(8'hC3, 1'b1);
        serial_rx = 1'b1;
      end
    join
    idle(10);
    check_sb("duplex_c3");

    // back-to-back transmit period
    @(posedge clk);
    #1;
    as_data_i  = 8'h33;
    as_dstrb_i = 1'b1;
    wait_busy_rise(c1, ok1);
    wait_busy_rise(c2, ok2);
    as_dstrb_i = 1'b0;
    chk("b2b_rises_seen", {ok1, ok2}, 2'b11);
    chk("b2b_period", c2 - c1, 10 * DIV + 1);
    idle(10 * DIV + 5);

    // reset during bit 3 of 0xFF, then 0x81
    @(posedge clk);
    #1;
    as_data_i  = 8'hFF;
    as_dstrb_i = 1'b1;
    @(posedge clk);
    #1;
    as_dstrb_i = 1'b0;
    repeat (35) @(posedge clk);
    #3;
    chk("mid_busy_before_reset", as_busy_o, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_serial_tx", serial_tx, 1'b1);
    chk("mid_rst_busy_o", as_busy_o, 1'b0);
    chk("mid_rst_tx_state", tx_state_o, 2'd0);
    idle(2);
    reset = 1'b1;
    idle(2);
    tx_check(8'h81);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
